// File: rtl/axi_lite_ram_slave_if.sv
// AXI4-Lite bus bundle between the core's data-side initiator and the RAM responder.
interface axi_lite_ram_slave_if;
  logic        AXI_AWVALID;
  logic        AXI_AWREADY;
  logic [31:0] AXI_AWADDR;
  logic [2:0]  AXI_AWPROT;
  logic        AXI_WVALID;
  logic        AXI_WREADY;
  logic [31:0] AXI_WDATA;
  logic [3:0]  AXI_WSTRB;
  logic        AXI_BVALID;
  logic        AXI_BREADY;
  logic [1:0]  AXI_BRESP;
  logic        AXI_ARVALID;
  logic        AXI_ARREADY;
  logic [31:0] AXI_ARADDR;
  logic [2:0]  AXI_ARPROT;
  logic        AXI_RVALID;
  logic        AXI_RREADY;
  logic [31:0] AXI_RDATA;
  logic [1:0]  AXI_RRESP;

  modport slave (
    input  AXI_AWVALID, AXI_AWADDR, AXI_AWPROT, AXI_WVALID, AXI_WDATA, AXI_WSTRB,
           AXI_BREADY, AXI_ARVALID, AXI_ARADDR, AXI_ARPROT, AXI_RREADY,
    output AXI_AWREADY, AXI_WREADY, AXI_BVALID, AXI_BRESP,
           AXI_ARREADY, AXI_RVALID, AXI_RDATA, AXI_RRESP
  );

  modport master (
    output AXI_AWVALID, AXI_AWADDR, AXI_AWPROT, AXI_WVALID, AXI_WDATA, AXI_WSTRB,
           AXI_BREADY, AXI_ARVALID, AXI_ARADDR, AXI_ARPROT, AXI_RREADY,
    input  AXI_AWREADY, AXI_WREADY, AXI_BVALID, AXI_BRESP,
           AXI_ARREADY, AXI_RVALID, AXI_RDATA, AXI_RRESP
  );
endinterface

// File: rtl/axi_lite_ram_slave.sv
// AXI4-Lite responder over a single-clock byte-writable RAM; independent write and
// read FSMs, SLVERR for addresses outside the RAM window.
//
// state    | meaning
// W_IDLE   | collecting AW and W beats, each READY high until its beat is held
// W_COMMIT | one cycle: byte-masked RAM write (if in range), raise BVALID
// W_RESP   | BVALID/BRESP held until BREADY
// R_IDLE   | ARREADY high, waiting for a read address
// R_MEM    | one cycle: synchronous RAM read
// R_RESP   | RVALID/RDATA/RRESP held until RREADY
module axi_lite_ram_slave #(
  parameter int unsigned MEM_AW    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic clk,
  input logic rst_n,
  axi_lite_ram_slave_if.slave s_axi
);
  localparam int unsigned DEPTH = 2 ** MEM_AW;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_MEM, R_RESP} r_state_e;

  w_state_e    w_state_q, w_state_d;
  r_state_e    r_state_q, r_state_d;
  logic        awready_q, awready_d, wready_q, wready_d;
  logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        arready_q, arready_d, rvalid_q, rvalid_d, rerr_q, rerr_d;
  logic [31:0] araddr_q, araddr_d, rd_word_q;
  logic [31:0] mem_q [DEPTH];

  logic [31:0] wr_off, rd_off;
  logic        wr_ok, rd_ok, aw_hs, w_hs, ar_hs, mem_we;
  logic        unused_prot;

  // The subtraction wraps for addresses below the base, so the >= test is still needed.
  assign wr_off = awaddr_q - BASE_ADDR;
  assign rd_off = araddr_q - BASE_ADDR;
  assign wr_ok  = (awaddr_q >= BASE_ADDR) && ((wr_off >> (MEM_AW + 2)) == 32'd0);
  assign rd_ok  = (araddr_q >= BASE_ADDR) && ((rd_off >> (MEM_AW + 2)) == 32'd0);

  assign aw_hs  = s_axi.AXI_AWVALID && awready_q;
  assign w_hs   = s_axi.AXI_WVALID && wready_q;
  assign ar_hs  = s_axi.AXI_ARVALID && arready_q;
  assign mem_we = (w_state_q == W_COMMIT) && wr_ok;
  assign unused_prot = ^{s_axi.AXI_AWPROT, s_axi.AXI_ARPROT};

  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_axi.AXI_AWADDR;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi.AXI_WDATA;
          wstrb_d  = s_axi.AXI_WSTRB;
        end
        awready_d = !aw_held_d;
        wready_d  = !w_held_d;
        if (aw_held_d && w_held_d) w_state_d = W_COMMIT;
      end
      W_COMMIT: begin
        bvalid_d  = 1'b1;
        bresp_d   = wr_ok ? 2'b00 : 2'b10;
        w_state_d = W_RESP;
      end
      W_RESP: begin
        if (s_axi.AXI_BREADY) begin
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    araddr_d  = araddr_q;
    rvalid_d  = rvalid_q;
    rerr_d    = rerr_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          araddr_d  = s_axi.AXI_ARADDR;
          arready_d = 1'b0;
          r_state_d = R_MEM;
        end else begin
          arready_d = 1'b1;
        end
      end
      R_MEM: begin
        rvalid_d  = 1'b1;
        rerr_d    = !rd_ok;
        r_state_d = R_RESP;
      end
      R_RESP: begin
        if (s_axi.AXI_RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      araddr_q  <= '0;
      rvalid_q  <= 1'b0;
      rerr_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      araddr_q  <= araddr_d;
      rvalid_q  <= rvalid_d;
      rerr_q    <= rerr_d;
    end
  end

  // Read and write share the edge, so a same-word collision returns the old data.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem_q[wr_off[MEM_AW+1:2]][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
    if (r_state_q == R_MEM) rd_word_q <= mem_q[rd_off[MEM_AW+1:2]];
  end

  assign s_axi.AXI_AWREADY = awready_q;
  assign s_axi.AXI_WREADY  = wready_q;
  assign s_axi.AXI_BVALID  = bvalid_q;
  assign s_axi.AXI_BRESP   = bresp_q;
  assign s_axi.AXI_ARREADY = arready_q;
  assign s_axi.AXI_RVALID  = rvalid_q;
  assign s_axi.AXI_RDATA   = (rvalid_q && !rerr_q) ? rd_word_q : 32'h0;
  assign s_axi.AXI_RRESP   = {rvalid_q && rerr_q, 1'b0};
endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Bench for axi_lite_ram_slave: directed vector table, hand-written corner sequences,
// then random traffic checked against a flat-array memory model.
module tb_axi_lite_ram_slave;
  localparam int          AW    = 6;
  localparam int          DEPTH = 2 ** AW;
  localparam logic [31:0] BASE  = 32'h0001_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axi_lite_ram_slave_if bus ();

  axi_lite_ram_slave #(.MEM_AW(AW), .BASE_ADDR(BASE)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .s_axi(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [DEPTH];

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
  } vec_t;
  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  function automatic bit m_in_range(input logic [31:0] a);
    longint unsigned la;
    la = a;
    return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * DEPTH);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    return m_in_range(a) ? ref_mem[m_idx(a)] : 32'h0;
  endfunction

  function automatic logic [1:0] m_resp(input logic [31:0] a);
    return m_in_range(a) ? 2'b00 : 2'b10;
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    if (!m_in_range(a)) return;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    ref_mem[m_idx(a)] = (ref_mem[m_idx(a)] & ~mask) | (d & mask);
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = int'($urandom_range(0, 9));
    if (sel == 0) return BASE + 4 * DEPTH + $urandom_range(0, 1023);
    if (sel == 1) return BASE - 1 - $urandom_range(0, 1023);
    return BASE + $urandom_range(0, 4 * DEPTH - 1);
  endfunction

  // Called at a negedge with the write channel idle; returns at a negedge after the B handshake.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly, input logic [1:0] exp_resp);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int cyc = 0;
    while (!(aw_done && w_done)) begin
      bus.AXI_AWVALID = !aw_done && (cyc >= aw_dly);
      bus.AXI_AWADDR  = addr;
      bus.AXI_AWPROT  = 3'($urandom);
      bus.AXI_WVALID  = !w_done && (cyc >= w_dly);
      bus.AXI_WDATA   = data;
      bus.AXI_WSTRB   = strb;
      if (aw_done) check("awready_after_capture", bus.AXI_AWREADY, 0);
      if (w_done) check("wready_after_capture", bus.AXI_WREADY, 0);
      aw_hs = bus.AXI_AWVALID && bus.AXI_AWREADY;
      w_hs  = bus.AXI_WVALID && bus.AXI_WREADY;
      @(negedge clk);
      cyc++;
      aw_done = aw_done | aw_hs;
      w_done  = w_done | w_hs;
      if (cyc > 40) begin
        timeout("write_accept");
        break;
      end
    end
    bus.AXI_AWVALID = 0;
    bus.AXI_WVALID  = 0;
    check("bvalid_in_commit", bus.AXI_BVALID, 0);
    @(negedge clk);
    check("bvalid_latency", bus.AXI_BVALID, 1);
    cyc = 0;
    while (!bus.AXI_BVALID && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.AXI_BVALID) timeout("bvalid");
    for (int i = 0; i < b_dly; i++) begin
      check("bvalid_hold", bus.AXI_BVALID, 1);
      check("bresp_hold", bus.AXI_BRESP, exp_resp);
      check("awready_in_resp", bus.AXI_AWREADY, 0);
      check("wready_in_resp", bus.AXI_WREADY, 0);
      @(negedge clk);
    end
    check("bresp", bus.AXI_BRESP, exp_resp);
    bus.AXI_BREADY = 1;
    @(negedge clk);
    bus.AXI_BREADY = 0;
    check("bvalid_after_hs", bus.AXI_BVALID, 0);
    check("awready_after_hs", bus.AXI_AWREADY, 1);
    check("wready_after_hs", bus.AXI_WREADY, 1);
  endtask

  // Called at a negedge with the read channel idle; returns at a negedge after the R handshake.
  task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp);
    bit hs = 0;
    int cyc = 0;
    repeat (ar_dly) @(negedge clk);
    while (!hs) begin
      bus.AXI_ARVALID = 1;
      bus.AXI_ARADDR  = addr;
      bus.AXI_ARPROT  = 3'($urandom);
      hs = bus.AXI_ARREADY;
      @(negedge clk);
      cyc++;
      if (cyc > 40) begin
        timeout("read_accept");
        break;
      end
    end
    bus.AXI_ARVALID = 0;
    check("rvalid_in_mem", bus.AXI_RVALID, 0);
    @(negedge clk);
    check("rvalid_latency", bus.AXI_RVALID, 1);
    cyc = 0;
    while (!bus.AXI_RVALID && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.AXI_RVALID) timeout("rvalid");
    for (int i = 0; i < r_dly; i++) begin
      check("rvalid_hold", bus.AXI_RVALID, 1);
      check("rdata_hold", bus.AXI_RDATA, exp_data);
      check("rresp_hold", bus.AXI_RRESP, exp_resp);
      check("arready_in_resp", bus.AXI_ARREADY, 0);
      @(negedge clk);
    end
    check("rdata", bus.AXI_RDATA, exp_data);
    check("rresp", bus.AXI_RRESP, exp_resp);
    bus.AXI_RREADY = 1;
    @(negedge clk);
    bus.AXI_RREADY = 0;
    check("rvalid_after_hs", bus.AXI_RVALID, 0);
    check("arready_after_hs", bus.AXI_ARREADY, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    vecs[0]  = '{1'b1, 32'h0001_0000, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0};
    vecs[1]  = '{1'b1, 32'h0001_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
    vecs[2]  = '{1'b0, 32'h0001_0010, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 32'h0001_0020, 32'h1122_3344, 4'hF, 2'b00, 32'h0};
    vecs[4]  = '{1'b1, 32'h0001_0020, 32'hAABB_CCDD, 4'h5, 2'b00, 32'h0};
    vecs[5]  = '{1'b0, 32'h0001_0020, 32'h0,         4'h0, 2'b00, 32'h11BB_33DD};
    vecs[6]  = '{1'b1, 32'h0001_0020, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0};
    vecs[7]  = '{1'b0, 32'h0001_0020, 32'h0,         4'h0, 2'b00, 32'h11BB_33DD};
    vecs[8]  = '{1'b1, 32'h0001_0100, 32'h1234_5678, 4'hF, 2'b10, 32'h0};
    vecs[9]  = '{1'b0, 32'h0001_0100, 32'h0,         4'h0, 2'b10, 32'h0};
    vecs[10] = '{1'b0, 32'h0001_0000, 32'h0,         4'h0, 2'b00, 32'hCAFE_F00D};
    vecs[11] = '{1'b1, 32'h0001_00FE, 32'h5566_7788, 4'hF, 2'b00, 32'h0};
    vecs[12] = '{1'b0, 32'h0001_00FC, 32'h0,         4'h0, 2'b00, 32'h5566_7788};
    vecs[13] = '{1'b1, 32'h0000_FFFC, 32'h0BAD_BAD0, 4'hF, 2'b10, 32'h0};
    vecs[14] = '{1'b0, 32'h0000_FFFC, 32'h0,         4'h0, 2'b10, 32'h0};
    vecs[15] = '{1'b0, 32'h0001_00FC, 32'h0,         4'h0, 2'b00, 32'h5566_7788};
    vecs[16] = '{1'b0, 32'h0001_0013, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};

    rst_n = 0;
    bus.AXI_AWVALID = 0; bus.AXI_AWADDR = 0; bus.AXI_AWPROT = 0;
    bus.AXI_WVALID = 0; bus.AXI_WDATA = 0; bus.AXI_WSTRB = 0; bus.AXI_BREADY = 0;
    bus.AXI_ARVALID = 0; bus.AXI_ARADDR = 0; bus.AXI_ARPROT = 0; bus.AXI_RREADY = 0;
    repeat (3) @(negedge clk);
    check("rst_awready", bus.AXI_AWREADY, 0);
    check("rst_wready", bus.AXI_WREADY, 0);
    check("rst_arready", bus.AXI_ARREADY, 0);
    check("rst_bvalid", bus.AXI_BVALID, 0);
    check("rst_rvalid", bus.AXI_RVALID, 0);
    check("rst_bresp", bus.AXI_BRESP, 0);
    check("rst_rresp", bus.AXI_RRESP, 0);
    check("rst_rdata", bus.AXI_RDATA, 0);
    rst_n = 1;
    check("arready_before_edge", bus.AXI_ARREADY, 0);
    @(negedge clk);
    check("awready_after_rst", bus.AXI_AWREADY, 1);
    check("wready_after_rst", bus.AXI_WREADY, 1);
    check("arready_after_rst", bus.AXI_ARREADY, 1);

    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      do_write(BASE + 4 * i, d, 4'hF, 0, 0, 0, 2'b00);
      m_write(BASE + 4 * i, d, 4'hF);
    end

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0, vecs[i].exp_resp);
        m_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      end else begin
        do_read(vecs[i].addr, 0, 0, vecs[i].exp_data, vecs[i].exp_resp);
      end
    end

    // W beat leads AW by 3 cycles, then AW leads W by 2.
    do_write(BASE + 32'h30, 32'h0102_0304, 4'hF, 3, 0, 0, 2'b00);
    m_write(BASE + 32'h30, 32'h0102_0304, 4'hF);
    do_write(BASE + 32'h34, 32'hA5A5_5A5A, 4'hF, 0, 2, 0, 2'b00);
    m_write(BASE + 32'h34, 32'hA5A5_5A5A, 4'hF);
    do_read(BASE + 32'h30, 0, 0, 32'h0102_0304, 2'b00);
    do_read(BASE + 32'h34, 0, 0, 32'hA5A5_5A5A, 2'b00);

    do_write(BASE + 32'h40, 32'h7777_0000, 4'hC, 0, 0, 5, 2'b00);
    m_write(BASE + 32'h40, 32'h7777_0000, 4'hC);
    do_read(BASE + 32'h40, 0, 5, m_read(BASE + 32'h40), 2'b00);
    do_write(BASE + 4 * DEPTH, 32'h1, 4'hF, 0, 0, 5, 2'b10);
    do_read(BASE + 4 * DEPTH, 0, 5, 32'h0, 2'b10);

    // Read's R_MEM and write's W_COMMIT coincide on one word: old data returned.
    d = m_read(BASE + 32'h50);
    fork
      do_write(BASE + 32'h50, 32'h5050_5050, 4'hF, 0, 0, 0, 2'b00);
      do_read(BASE + 32'h50, 0, 0, d, 2'b00);
    join
    m_write(BASE + 32'h50, 32'h5050_5050, 4'hF);
    do_read(BASE + 32'h50, 0, 0, 32'h5050_5050, 2'b00);

    // Reset while the read response is pending.
    bus.AXI_ARVALID = 1;
    bus.AXI_ARADDR  = BASE + 32'h10;
    check("rst_seq_arready", bus.AXI_ARREADY, 1);
    @(negedge clk);
    bus.AXI_ARVALID = 0;
    @(negedge clk);
    check("rst_seq_rvalid", bus.AXI_RVALID, 1);
    #2 rst_n = 0;
    #1;
    check("rst_async_rvalid", bus.AXI_RVALID, 0);
    check("rst_async_rdata", bus.AXI_RDATA, 0);
    check("rst_async_arready", bus.AXI_ARREADY, 0);
    @(negedge clk);
    rst_n = 1;
    check("rst_rel_arready", bus.AXI_ARREADY, 0);
    @(negedge clk);
    check("rst_rel_arready_edge", bus.AXI_ARREADY, 1);
    check("rst_rel_rvalid", bus.AXI_RVALID, 0);
    do_read(BASE + 32'h10, 0, 0, 32'hDEAD_BEEF, 2'b00);

    for (int it = 0; it < 60; it++) begin
      int kind;
      logic [31:0] wa, ra, wd, rexp;
      logic [3:0] ws;
      kind = int'($urandom_range(0, 2));
      wa = rand_addr();
      ra = rand_addr();
      wd = $urandom;
      ws = 4'($urandom);
      if (kind == 2 && m_in_range(wa) && m_in_range(ra) && m_idx(wa) == m_idx(ra)) ra = ra ^ 32'h4;
      if (kind == 0) begin
        do_write(wa, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), m_resp(wa));
        m_write(wa, wd, ws);
      end else if (kind == 1) begin
        do_read(ra, $urandom_range(0, 2), $urandom_range(0, 3), m_read(ra), m_resp(ra));
      end else begin
        rexp = m_read(ra);
        fork
          do_write(wa, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), m_resp(wa));
          do_read(ra, $urandom_range(0, 2), $urandom_range(0, 3), rexp, m_resp(ra));
        join
        m_write(wa, wd, ws);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
